// File: rtl/instruction_fetch_queue.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | instruction_fetch_queue: fetch PC, one-outstanding imem reads, PC/inst FIFO |
// | Rev 1.0                                                                    |
// +--------------------------------------------------------------------------+
module instruction_fetch_queue #(
  parameter int                    DATA_WIDTH = 32,
  parameter int                    DEPTH      = 4,
  parameter logic [DATA_WIDTH-1:0] RESET_PC   = '0
) (
  input  logic                         clk,
  input  logic                         rstn,
  output logic                         imem_req,
  output logic [DATA_WIDTH-1:0]        imem_addr,
  input  logic                         imem_ack,
  input  logic [DATA_WIDTH-1:0]        imem_rdata,
  input  logic                         redirect,
  input  logic [DATA_WIDTH-1:0]        redirect_pc,
  output logic                         inst_valid,
  output logic [DATA_WIDTH-1:0]        inst,
  output logic [DATA_WIDTH-1:0]        inst_pc,
  input  logic                         deq_ready,
  output logic [$clog2(DEPTH):0]       count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_WAIT    = 2'd1;
  localparam logic [1:0] S_DISCARD = 2'd2;

  localparam logic [DATA_WIDTH-1:0] C_STEP = DATA_WIDTH'(4);

  logic [1:0]            r_state, w_state_nxt;
  logic [DATA_WIDTH-1:0] r_req_pc, w_req_pc_nxt;
  logic [DATA_WIDTH-1:0] r_fpc, w_fpc_nxt;
  logic [CW-1:0]         r_count;
  logic [PW-1:0]         r_head, r_tail;
  logic [DATA_WIDTH-1:0] r_inst_mem [DEPTH];
  logic [DATA_WIDTH-1:0] r_pc_mem   [DEPTH];

  logic                  w_flush, w_push, w_deq, w_room;
  logic [DATA_WIDTH-1:0] w_redirect_pc, w_disc_pc;

  assign w_redirect_pc = redirect_pc & ~DATA_WIDTH'(3);
  assign w_deq         = inst_valid & deq_ready;
  assign w_room        = (r_count + CW'(1) - CW'(w_deq)) < CW'(DEPTH);
  // In DISCARD the restart PC is whatever fpc becomes this cycle.
  assign w_disc_pc     = redirect ? w_redirect_pc : r_fpc;

  always_ff @(posedge clk) begin
    if (rstn) begin
      r_state  <= S_IDLE;
      r_req_pc <= RESET_PC;
      r_fpc    <= RESET_PC;
    end else begin
      r_state  <= w_state_nxt;
      r_req_pc <= w_req_pc_nxt;
      r_fpc    <= w_fpc_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_req_pc_nxt = r_req_pc;
    w_fpc_nxt    = r_fpc;
    w_flush      = 1'b0;
    w_push       = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (redirect) begin
          w_flush      = 1'b1;
          w_req_pc_nxt = w_redirect_pc;
          w_fpc_nxt    = w_redirect_pc + C_STEP;
          w_state_nxt  = S_WAIT;
        end else if (r_count < CW'(DEPTH)) begin
          w_req_pc_nxt = r_fpc;
          w_fpc_nxt    = r_fpc + C_STEP;
          w_state_nxt  = S_WAIT;
        end
      end
      S_WAIT: begin
        if (redirect && imem_ack) begin
          w_flush      = 1'b1;
          w_req_pc_nxt = w_redirect_pc;
          w_fpc_nxt    = w_redirect_pc + C_STEP;
        end else if (redirect) begin
          w_flush      = 1'b1;
          w_fpc_nxt    = w_redirect_pc;
          w_state_nxt  = S_DISCARD;
        end else if (imem_ack) begin
          w_push = 1'b1;
          if (w_room) begin
            w_req_pc_nxt = r_fpc;
            w_fpc_nxt    = r_fpc + C_STEP;
          end else begin
            w_state_nxt  = S_IDLE;
          end
        end
      end
      S_DISCARD: begin
        if (redirect) begin
          w_flush   = 1'b1;
          w_fpc_nxt = w_redirect_pc;
        end
        if (imem_ack) begin
          w_req_pc_nxt = w_disc_pc;
          w_fpc_nxt    = w_disc_pc + C_STEP;
          w_state_nxt  = S_WAIT;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_comb begin
    imem_req   = (r_state != S_IDLE);
    imem_addr  = r_req_pc;
    inst_valid = (r_count != '0);
    inst       = r_inst_mem[r_head];
    inst_pc    = r_pc_mem[r_head];
    count      = r_count;
  end

  // Flush wins over any same-cycle push or dequeue.
  always_ff @(posedge clk) begin
    if (rstn) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_inst_mem[i] <= '0;
        r_pc_mem[i]   <= '0;
      end
    end else if (w_flush) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_inst_mem[r_tail] <= imem_rdata;
        r_pc_mem[r_tail]   <= r_req_pc;
        r_tail             <= r_tail + PW'(1);
      end
      if (w_deq) begin
        r_head <= r_head + PW'(1);
      end
      case ({w_push, w_deq})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: doc/instruction_fetch_queue.md
# instruction_fetch_queue

Instruction fetch front end placed between the instruction memory and the decode stage. It owns the fetch PC and issues one-outstanding-request reads to a variable-latency instruction memory. Returned words go into a small FIFO with their PCs, and decode drains them through a valid/ready handshake. A redirect from branch resolution flushes the FIFO, discards any in-flight response and restarts fetch at the new PC.

## Interface
- DATA_WIDTH, 32, instruction and address width
- DEPTH, 4, FIFO entries; power of two, at least 2
- RESET_PC, 32'h0000_0000, first fetch address after reset

- clk  in  1  clock; all state updates on rising edge
- rstn  in  1  one clock; reset is synchronous and active-high: rstn=1 at a rising edge resets the block
- imem_req  out  1  read request; held high while a request is outstanding
- imem_addr  out  DATA_WIDTH  request address; stable while imem_req=1 until ack
- imem_ack  in  1  one-cycle pulse; completes the current request; ignored when imem_req=0
- imem_rdata  in  DATA_WIDTH  instruction word; valid when imem_ack=1
- redirect  in  1  one-cycle pulse; flush and restart fetch at redirect_pc
- redirect_pc  in  DATA_WIDTH  new fetch PC; bits [1:0] forced to 0
- inst_valid  out  1  FIFO head valid, i.e. count != 0
- inst  out  DATA_WIDTH  head instruction
- inst_pc  out  DATA_WIDTH  head PC
- deq_ready  in  1  decode consumes the head when inst_valid=1 and deq_ready=1
- count  out  clog2(DEPTH)+1  current FIFO occupancy

## Operation
- Registers: state, req_pc (drives imem_addr), fpc (next PC to fetch), FIFO storage, head/tail pointers, count.
- States:
  - IDLE: imem_req=0.
  - WAIT: imem_req=1, request outstanding.
  - DISCARD: imem_req=1, the outstanding response will be dropped.
- Define deq = inst_valid & deq_ready, and room = (count + 1 - deq) < DEPTH.
- IDLE:
  - redirect: flush; req_pc <= redirect_pc; fpc <= redirect_pc+4; go to WAIT.
  - else if count < DEPTH: req_pc <= fpc; fpc <= fpc+4; go to WAIT.
- WAIT, redirect & imem_ack: drop rdata; flush; req_pc <= redirect_pc; fpc <= redirect_pc+4; stay in WAIT.
- WAIT, redirect & !imem_ack: flush; fpc <= redirect_pc; go to DISCARD.
- WAIT, imem_ack only: push {req_pc, imem_rdata}.
  - room: req_pc <= fpc; fpc <= fpc+4; stay in WAIT.
  - not room: go to IDLE (fpc is already the next PC).
- DISCARD:
  - redirect: flush; fpc <= redirect_pc.
  - imem_ack (alone or with redirect): drop rdata; req_pc <= the fpc in effect after this cycle's update; fpc <= that value + 4; go to WAIT.
- Flush clears count and pointers. It overrides the same-cycle deq and push.
- FIFO behaviour:
  - Simultaneous push and pop is allowed; count is unchanged.
  - There is no bypass: a word pushed into an empty FIFO becomes visible the next cycle.
  - A push never occurs at count=DEPTH, guaranteed by the room/count checks.
- PC arithmetic is modulo 2^DATA_WIDTH; 0xFFFF_FFFC+4 wraps to 0.

## Timing
- Reset values: state=IDLE, imem_req=0, imem_addr=RESET_PC, fpc=RESET_PC, count=0, inst_valid=0, inst=0, inst_pc=0, pointers=0.
- First cycle after reset release: IDLE. imem_req=1 with imem_addr=RESET_PC on the following cycle.
- imem_ack at edge t means the word is at the FIFO head (inst_valid=1) in cycle t+1.
- With a zero-wait memory (ack in the first cycle of each request) and deq_ready=1, throughput is one instruction per cycle.
- Redirect at edge t in IDLE or WAIT+ack: the new request appears in cycle t+1.
- Redirect in WAIT without ack: the new request appears the cycle after the old ack.
- Reset during WAIT or DISCARD: the next cycle is IDLE with imem_req=0. A late ack arriving while imem_req=0 is ignored. The memory must tolerate a dropped request.

## Test plan
- Reset, zero-wait memory returning word = addr ^ 0xA5A5_0000, deq_ready=1 -> imem_addr steps 0,4,8,... each cycle; inst_pc/inst pairs match (0, 0xA5A5_0000), (4, 0xA5A5_0004), ... with no gaps.
- DEPTH=4, deq_ready=0 -> count reaches 4; imem_req=0 with fpc=0x10; inst_pc stays 0. Raise deq_ready -> next request at 0x10; in-order delivery from 0.
- 3-cycle memory latency, redirect to 0x200 one cycle after a request to 0x08 -> state DISCARD; the 0x08 word never enqueued; count=0; next imem_addr=0x200.
- Redirect to 0x103 coincident with imem_ack for 0x0C -> ack data dropped; count=0 next cycle; imem_addr=0x100 next cycle.
- count=3 (DEPTH=4), imem_ack and deq in the same cycle -> count stays 3; the request continues at fpc; no overflow.
- rstn=1 while WAIT, then a stray imem_ack after release -> not enqueued; imem_addr restarts at RESET_PC; inst_valid=0 until the first real ack.
